// File: rtl/morse_key_decoder_if.sv
// Signal bundle between the telegraph key / seven-segment pins and the
// Morse decoder. The board side (master) drives the key level and observes
// the decoded letter; the decoder (slave) does the opposite.
interface morse_key_decoder_if;
    logic       key_i;
    logic [6:0] seg_o;
    logic [4:0] letter_o;
    logic       valid_o;
    logic       error_o;
    logic       busy_o;

    modport master (
        output key_i,
        input  seg_o, letter_o, valid_o, error_o, busy_o
    );

    modport slave (
        input  key_i,
        output seg_o, letter_o, valid_o, error_o, busy_o
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Live Morse decoder: synchronises the raw key, times each press as dot or
// dash, collects up to four symbols per letter and, once a letter gap has
// elapsed, emits the letter index and its seven-segment pattern.
module morse_key_decoder #(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    morse_key_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       LETTER_BAD = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_EMIT
    } state_e;

    // Map (length, code) to a letter index; first symbol is the MSB of the
    // valid bits, dot = 0, dash = 1. Anything not in ITU A-Z returns 31.
    function automatic logic [4:0] decode_letter(input logic [2:0] len,
                                                 input logic [3:0] code);
        logic [4:0] idx;
        idx = LETTER_BAD;
        case ({len, code})
            {3'd2, 4'b0001}: idx = 5'd0;   // A .-
            {3'd4, 4'b1000}: idx = 5'd1;   // B -...
            {3'd4, 4'b1010}: idx = 5'd2;   // C -.-.
            {3'd3, 4'b0100}: idx = 5'd3;   // D -..
            {3'd1, 4'b0000}: idx = 5'd4;   // E .
            {3'd4, 4'b0010}: idx = 5'd5;   // F ..-.
            {3'd3, 4'b0110}: idx = 5'd6;   // G --.
            {3'd4, 4'b0000}: idx = 5'd7;   // H ....
            {3'd2, 4'b0000}: idx = 5'd8;   // I ..
            {3'd4, 4'b0111}: idx = 5'd9;   // J .---
            {3'd3, 4'b0101}: idx = 5'd10;  // K -.-
            {3'd4, 4'b0100}: idx = 5'd11;  // L .-..
            {3'd2, 4'b0011}: idx = 5'd12;  // M --
            {3'd2, 4'b0010}: idx = 5'd13;  // N -.
            {3'd3, 4'b0111}: idx = 5'd14;  // O ---
            {3'd4, 4'b0110}: idx = 5'd15;  // P .--.
            {3'd4, 4'b1101}: idx = 5'd16;  // Q --.-
            {3'd3, 4'b0010}: idx = 5'd17;  // R .-.
            {3'd3, 4'b0000}: idx = 5'd18;  // S ...
            {3'd1, 4'b0001}: idx = 5'd19;  // T -
            {3'd3, 4'b0001}: idx = 5'd20;  // U ..-
            {3'd4, 4'b0001}: idx = 5'd21;  // V ...-
            {3'd3, 4'b0011}: idx = 5'd22;  // W .--
            {3'd4, 4'b1001}: idx = 5'd23;  // X -..-
            {3'd4, 4'b1011}: idx = 5'd24;  // Y -.--
            {3'd4, 4'b1100}: idx = 5'd25;  // Z --..
            default:         idx = LETTER_BAD;
        endcase
        return idx;
    endfunction

    // Seven-segment font for letter indices 0..25; blank otherwise.
    function automatic logic [6:0] letter_font(input logic [4:0] idx);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (idx)
            5'd0:  seg = 7'b1011111;
            5'd1:  seg = 7'b1111100;
            5'd2:  seg = 7'b1011000;
            5'd3:  seg = 7'b1011110;
            5'd4:  seg = 7'b1111001;
            5'd5:  seg = 7'b1110001;
            5'd6:  seg = 7'b0111101;
            5'd7:  seg = 7'b1110110;
            5'd8:  seg = 7'b0010001;
            5'd9:  seg = 7'b0001101;
            5'd10: seg = 7'b1110101;
            5'd11: seg = 7'b0111000;
            5'd12: seg = 7'b1010101;
            5'd13: seg = 7'b1010100;
            5'd14: seg = 7'b1011100;
            5'd15: seg = 7'b1110011;
            5'd16: seg = 7'b1100111;
            5'd17: seg = 7'b1010000;
            5'd18: seg = 7'b1101101;
            5'd19: seg = 7'b1111000;
            5'd20: seg = 7'b0011100;
            5'd21: seg = 7'b0101010;
            5'd22: seg = 7'b1101010;
            5'd23: seg = 7'b0110110;
            5'd24: seg = 7'b1101110;
            5'd25: seg = 7'b1011011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic             key_meta_q, key_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] press_q, press_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gap_inc;
    logic [2:0]       len_q, len_d;
    logic [3:0]       code_q, code_d;
    logic             ovf_q, ovf_d;
    logic [6:0]       seg_q, seg_d;
    logic [4:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             sym;
    logic [4:0]       dec_idx;

    // Two-flop synchroniser bringing the asynchronous key level into clk.
    // NOTE: registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
        end else begin
            key_meta_q <= bus.key_i;
            key_s_q    <= key_meta_q;
        end
    end

    assign sym     = (press_q >= DASH_MIN);
    assign gap_inc = gap_q + CNT_ONE;
    assign dec_idx = decode_letter(len_q, code_q);

    // Next-state, symbol accumulation and emit decode.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        press_d  = press_q;
        gap_d    = gap_q;
        len_d    = len_q;
        code_d   = code_q;
        ovf_d    = ovf_q;
        seg_d    = seg_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_s_q) begin
                    state_d = ST_PRESS;
                    press_d = CNT_ONE;
                end
            end
            ST_PRESS: begin
                if (key_s_q) begin
                    if (press_q != '1) press_d = press_q + CNT_ONE;
                end else begin
                    if (len_q == 3'd4) begin
                        ovf_d = 1'b1;
                    end else begin
                        code_d = {code_q[2:0], sym};
                        len_d  = len_q + 3'd1;
                    end
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (key_s_q) begin
                    state_d = ST_PRESS;
                    press_d = CNT_ONE;
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_END) begin
                        state_d = ST_EMIT;
                        valid_d = 1'b1;
                        if (ovf_q || dec_idx == LETTER_BAD) begin
                            letter_d = LETTER_BAD;
                            seg_d    = 7'b0000000;
                            error_d  = 1'b1;
                        end else begin
                            letter_d = dec_idx;
                            seg_d    = letter_font(dec_idx);
                        end
                    end
                end
            end
            ST_EMIT: begin
                len_d  = 3'd0;
                code_d = 4'd0;
                ovf_d  = 1'b0;
                if (key_s_q) begin
                    state_d = ST_PRESS;
                    press_d = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, symbol register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            press_q  <= '0;
            gap_q    <= '0;
            len_q    <= 3'd0;
            code_q   <= 4'd0;
            ovf_q    <= 1'b0;
            seg_q    <= 7'b0000000;
            letter_q <= LETTER_BAD;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            press_q  <= press_d;
            gap_q    <= gap_d;
            len_q    <= len_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
            seg_q    <= seg_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.seg_o    = seg_q;
    assign bus.letter_o = letter_q;
    assign bus.valid_o  = valid_q;
    assign bus.error_o  = error_q;
    assign bus.busy_o   = (state_q == ST_PRESS) || (state_q == ST_GAP);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder with UNIT_CYCLES = 4: stimulus
// keys directed letters and queues the expected emit; a monitor pops and
// compares on every valid_o pulse.
module tb_morse_key_decoder;

    localparam int UNIT = 4;

    typedef struct packed {
        logic [4:0] letter;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pushed;
    int   emits;
    exp_t exp_q[$];
    exp_t mon_e;

    morse_key_decoder_if bus ();

    morse_key_decoder #(
        .UNIT_CYCLES (UNIT),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_letter(input logic [4:0] letter, input logic [6:0] seg,
                                 input logic err);
        exp_t e;
        e.letter = letter;
        e.seg    = seg;
        e.err    = err;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Key held for n sampling edges, then released.
    task automatic press(input int n);
        bus.key_i = 1'b1;
        repeat (n) @(negedge clk);
        bus.key_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},    {25'd0, bus.seg_o},    32'd0);
        check({tag, "_letter"}, {27'd0, bus.letter_o}, 32'd31);
        check({tag, "_valid"},  {31'd0, bus.valid_o},  32'd0);
        check({tag, "_error"},  {31'd0, bus.error_o},  32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy_o},   32'd0);
    endtask

    // Monitor: every emit must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_o) begin
                emits++;
                if (exp_q.size() == 0) begin
                    check("unexpected_emit", {27'd0, bus.letter_o}, 32'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("letter", {27'd0, bus.letter_o}, {27'd0, mon_e.letter});
                    check("seg",    {25'd0, bus.seg_o},    {25'd0, mon_e.seg});
                    check("error",  {31'd0, bus.error_o},  {31'd0, mon_e.err});
                end
            end else if (bus.error_o) begin
                check("error_without_valid", {31'd0, bus.error_o}, 32'd0);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        pushed    = 0;
        emits     = 0;
        rst_n     = 1'b0;
        bus.key_i = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(3);

        // E: single 4-cycle dot; busy while the press is pending.
        expect_letter(5'd4, 7'b1111001, 1'b0);
        press(4);
        check("busy_in_press", {31'd0, bus.busy_o}, 32'd1);
        idle(30);
        check("busy_idle", {31'd0, bus.busy_o}, 32'd0);

        // C: dash dot dash dot with 4-cycle gaps.
        expect_letter(5'd2, 7'b1011000, 1'b0);
        press(12); idle(4); press(4); idle(4);
        press(12); idle(4); press(4); idle(30);

        // A: dot, 11-cycle gap, dash - no emit at the gap.
        expect_letter(5'd0, 7'b1011111, 1'b0);
        press(4); idle(11); press(12); idle(30);

        // N: key rises in the last gap cycle, letter continues.
        expect_letter(5'd13, 7'b1010100, 1'b0);
        press(12); idle(12); press(4); idle(30);

        // E then T: key rises on the EMIT cycle and starts a new letter.
        expect_letter(5'd4, 7'b1111001, 1'b0);
        expect_letter(5'd19, 7'b1111000, 1'b0);
        press(4); idle(13); press(12); idle(30);

        // Five dots overflow -> error; next single dash decodes as T.
        expect_letter(5'd31, 7'b0000000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            press(4);
            idle(4);
        end
        idle(26);
        expect_letter(5'd19, 7'b1111000, 1'b0);
        press(12); idle(30);

        // ..-- is not a letter.
        expect_letter(5'd31, 7'b0000000, 1'b1);
        press(4); idle(4); press(4); idle(4);
        press(12); idle(4); press(12); idle(30);

        // Reset after two symbols discards them; then a dot is E.
        press(4); idle(4); press(4); idle(2);
        check("busy_before_abort", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        idle(2);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        idle(20);
        check("no_emit_after_abort", {31'd0, bus.letter_o}, 32'd31);
        expect_letter(5'd4, 7'b1111001, 1'b0);
        press(4); idle(30);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("emit_count", emits, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
